// File: rtl/dmem_pkg.sv
// dmem_pkg: encodings shared by the data-memory port controller.
// Access sizes, FSM states, requester ids, alignment helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DBG = 1'b1;

`ifdef DMEM_PORT_CTRL_SUBWORD_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    CAP     = 3'd2,
    RMW_RD  = 3'd3,
    RMW_MRG = 3'd4,
    WR      = 3'd5,
    ACK     = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd5,
    ACK  = 3'd6
  } state_e;
`endif

  function automatic logic is_subword(
    input logic [1:0] sz
  );
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

  // size 2'b11 behaves as a word
  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    return ((sz == SZ_HALF) && lo[0]) ||
           (sz[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// dmem_lane_merge: little-endian lane extract (load) and lane merge (store).
// Ports: size_i, lane_i, word_i (RAM word), store_i (right-justified) -> load_o, merge_o.
module dmem_lane_merge
  import dmem_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [1:0]         size_i,
  input  logic [1:0]         lane_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic [NB_DATA-1:0] store_i,
  output logic [NB_DATA-1:0] load_o,
  output logic [NB_DATA-1:0] merge_o
);

  localparam int SW = $clog2(NB_DATA);

  logic [SW-1:0]      sh;
  logic [NB_DATA-1:0] mask;

  always_comb begin
    sh   = '0;
    mask = '1;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        sh   = SW'({lane_i, 3'b000});
        mask = NB_DATA'(8'hFF) << sh;
      end
      (size_i == SZ_HALF): begin
        sh   = SW'({lane_i[1], 4'b0000});
        mask = NB_DATA'(16'hFFFF) << sh;
      end
      default: ;
    endcase
    load_o  = (word_i >> sh) & (mask >> sh);
    merge_o = (word_i & ~mask) |
              ((store_i << sh) & mask);
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: round-robin CPU/debug arbiter and sequencer for the
// single-port data BRAM. CPU req/we/size/addr/wdata -> rdata/ack/err;
// debug req/we/addr/wdata -> rdata/ack; RAM ena/wea/addr/wdata, rdata in.
// Macro DMEM_PORT_CTRL_SUBWORD_EN: byte/half access, RMW, misalign errors.
module dmem_port_ctrl
  import dmem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [1:0]         i_cpu_size,
  input  logic [NB_ADDR+1:0] i_cpu_addr,
  input  logic [NB_DATA-1:0] i_cpu_wdata,
  output logic [NB_DATA-1:0] o_cpu_rdata,
  output logic               o_cpu_ack,
  output logic               o_cpu_err,
  input  logic               i_dbg_req,
  input  logic               i_dbg_we,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_wdata,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  output logic               o_dbg_ack,
  output logic               o_ram_ena,
  output logic               o_ram_wea,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_DATA-1:0] o_ram_wdata,
  input  logic [NB_DATA-1:0] i_ram_rdata
);

  state_e state_q, state_d;

  logic               id_q, last_q;
  logic               gid, grant, mis;
  logic [NB_ADDR-1:0] addr_q;
  logic [1:0]         size_q, lo_q;
  logic [1:0]         cpu_size, cpu_lo;
  logic [NB_DATA-1:0] wbuf_q;
  logic [NB_DATA-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [NB_DATA-1:0] ld_data, mrg_data;

`ifdef DMEM_PORT_CTRL_SUBWORD_EN
  logic err_q;
  assign cpu_size = i_cpu_size;
  assign cpu_lo   = i_cpu_addr[1:0];
  assign mis      = misaligned(cpu_size, cpu_lo);
`else
  logic [NB_DATA+3:0] unused_cpu;
  assign unused_cpu = {i_cpu_size, i_cpu_addr[1:0], mrg_data};
  assign cpu_size   = SZ_WORD;
  assign cpu_lo     = 2'b00;
  assign mis        = 1'b0;
`endif

  // on a tie the requester not granted last wins
  assign gid = (i_cpu_req && i_dbg_req) ? ~last_q : i_dbg_req;

  dmem_lane_merge #(
    .NB_DATA (NB_DATA)
  ) u_lane (
    .size_i  (size_q),
    .lane_i  (lo_q),
    .word_i  (i_ram_rdata),
    .store_i (wbuf_q),
    .load_o  (ld_data),
    .merge_o (mrg_data)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_cpu_req || i_dbg_req) begin
          grant = 1'b1;
          if (gid == ID_DBG)
            state_d = i_dbg_we ? WR : RD;
          else if (mis)
            state_d = ACK;
          else if (!i_cpu_we)
            state_d = RD;
`ifdef DMEM_PORT_CTRL_SUBWORD_EN
          else if (is_subword(cpu_size))
            state_d = RMW_RD;
`endif
          else
            state_d = WR;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = ACK;
`ifdef DMEM_PORT_CTRL_SUBWORD_EN
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: state_d = WR;
`endif
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      id_q        <= ID_CPU;
      last_q      <= ID_CPU;
      addr_q      <= '0;
      size_q      <= SZ_WORD;
      lo_q        <= 2'b00;
      wbuf_q      <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
`ifdef DMEM_PORT_CTRL_SUBWORD_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q   <= gid;
        last_q <= gid;
        if (gid == ID_DBG) begin
          addr_q <= i_dbg_addr;
          size_q <= SZ_WORD;
          lo_q   <= 2'b00;
          wbuf_q <= i_dbg_wdata;
        end else begin
          addr_q <= i_cpu_addr[NB_ADDR+1:2];
          size_q <= cpu_size;
          lo_q   <= cpu_lo;
          wbuf_q <= i_cpu_wdata;
        end
`ifdef DMEM_PORT_CTRL_SUBWORD_EN
        err_q <= (gid == ID_CPU) && mis;
`endif
      end
      if (state_q == CAP) begin
        if (id_q == ID_CPU)
          cpu_rdata_q <= ld_data;
        else
          dbg_rdata_q <= ld_data;
      end
`ifdef DMEM_PORT_CTRL_SUBWORD_EN
      // write buffer takes the merged word for the WR beat
      if (state_q == RMW_MRG)
        wbuf_q <= mrg_data;
`endif
    end
  end

  always_comb begin
    o_ram_ena = 1'b0;
    o_ram_wea = 1'b0;
    unique case (state_q)
      RD:     o_ram_ena = 1'b1;
`ifdef DMEM_PORT_CTRL_SUBWORD_EN
      RMW_RD: o_ram_ena = 1'b1;
`endif
      WR: begin
        o_ram_ena = 1'b1;
        o_ram_wea = 1'b1;
      end
      default: ;
    endcase
    o_ram_addr  = o_ram_ena ? addr_q : '0;
    o_ram_wdata = o_ram_wea ? wbuf_q : '0;
  end

  assign o_cpu_ack   = (state_q == ACK) && (id_q == ID_CPU);
  assign o_dbg_ack   = (state_q == ACK) && (id_q == ID_DBG);
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_dbg_rdata = dbg_rdata_q;

`ifdef DMEM_PORT_CTRL_SUBWORD_EN
  assign o_cpu_err = o_cpu_ack && err_q;
`else
  assign o_cpu_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb_dmem_port_ctrl: scoreboard bench for dmem_port_ctrl with a BRAM model
// and a word-array reference model; honours DMEM_PORT_CTRL_SUBWORD_EN.
module tb_dmem_port_ctrl;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 10;
  localparam int DEPTH   = 1 << NB_ADDR;

  logic               clk = 1'b0;
  logic               rst;
  logic               init_mem;
  logic               cpu_req, cpu_we;
  logic [1:0]         cpu_size;
  logic [NB_ADDR+1:0] cpu_addr;
  logic [NB_DATA-1:0] cpu_wdata, cpu_rdata;
  logic               cpu_ack, cpu_err;
  logic               dbg_req, dbg_we;
  logic [NB_ADDR-1:0] dbg_addr;
  logic [NB_DATA-1:0] dbg_wdata, dbg_rdata;
  logic               dbg_ack;
  logic               ram_ena, ram_wea;
  logic [NB_ADDR-1:0] ram_addr;
  logic [NB_DATA-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_port_ctrl #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_size  (cpu_size),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_err   (cpu_err),
    .i_dbg_req   (dbg_req),
    .i_dbg_we    (dbg_we),
    .i_dbg_addr  (dbg_addr),
    .i_dbg_wdata (dbg_wdata),
    .o_dbg_rdata (dbg_rdata),
    .o_dbg_ack   (dbg_ack),
    .o_ram_ena   (ram_ena),
    .o_ram_wea   (ram_wea),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata)
  );

  // BRAM, low-latency read
  logic [NB_DATA-1:0] bram [DEPTH];
  int ena_cnt = 0;
  int wr_cnt  = 0;
  int cyc     = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++)
        bram[i] <= NB_DATA'(i);
    end else if (ram_ena) begin
      ena_cnt <= ena_cnt + 1;
      if (ram_wea) begin
        wr_cnt         <= wr_cnt + 1;
        bram[ram_addr] <= ram_wdata;
      end else begin
        ram_rdata <= bram[ram_addr];
      end
    end
  end

  // reference model
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          t0;
    int          lat;
  } exp_t;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] cpu_rd_m, dbg_rd_m;
  exp_t        cpu_q[$], dbg_q[$];
  int          ack_seq[$];
  int          vectors = 0;
  int          miscompares = 0;

  // monitor
  exp_t ec, ed;
  always @(negedge clk) begin
    if (cpu_ack) begin
      vectors++;
      ack_seq.push_back(0);
      if (cpu_q.size() == 0) begin
        miscompares++;
        $display("FAIL cpu_resp unexpected ack");
      end else begin
        ec = cpu_q.pop_front();
        if (cpu_rdata !== ec.data || cpu_err !== ec.err ||
            (ec.lat != 0 && cyc - ec.t0 != ec.lat)) begin
          miscompares++;
          $display("FAIL cpu_resp rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                   cpu_rdata, cpu_err, cyc - ec.t0, ec.data, ec.err, ec.lat);
        end
      end
    end
    if (dbg_ack) begin
      vectors++;
      ack_seq.push_back(1);
      if (dbg_q.size() == 0) begin
        miscompares++;
        $display("FAIL dbg_resp unexpected ack");
      end else begin
        ed = dbg_q.pop_front();
        if (dbg_rdata !== ed.data ||
            (ed.lat != 0 && cyc - ed.t0 != ed.lat)) begin
          miscompares++;
          $display("FAIL dbg_resp rdata=%h lat=%0d expected rdata=%h lat=%0d",
                   dbg_rdata, cyc - ed.t0, ed.data, ed.lat);
        end
      end
    end
  end

  task automatic cpu_issue(input logic we, input logic [1:0] size,
                           input logic [11:0] addr, input logic [31:0] wd,
                           input bit chk, output int n_ena, output int n_wr);
    exp_t e;
    logic [1:0] sz, lo;
    logic [9:0] w;
    logic [31:0] t;
    int sh, lat;
    bit mis;
    sz = size;
    lo = addr[1:0];
    w  = addr[11:2];
`ifndef DMEM_PORT_CTRL_SUBWORD_EN
    sz = 2'b10;
    lo = 2'b00;
`endif
    if (sz == 2'b11) sz = 2'b10;
    mis = (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
    t = ref_mem[w];
    n_ena = 0;
    n_wr  = 0;
    if (mis) begin
      lat = 1;
    end else if (we) begin
      n_wr = 1;
      if (sz == 2'b00) begin
        sh = 8 * lo;
        t[sh +: 8] = wd[7:0];
        lat = 4; n_ena = 2;
      end else if (sz == 2'b01) begin
        sh = 16 * lo[1];
        t[sh +: 16] = wd[15:0];
        lat = 4; n_ena = 2;
      end else begin
        t = wd;
        lat = 2; n_ena = 1;
      end
      ref_mem[w] = t;
    end else begin
      lat = 3; n_ena = 1;
      if (sz == 2'b00) begin
        sh = 8 * lo;
        cpu_rd_m = {24'h0, t[sh +: 8]};
      end else if (sz == 2'b01) begin
        sh = 16 * lo[1];
        cpu_rd_m = {16'h0, t[sh +: 16]};
      end else begin
        cpu_rd_m = t;
      end
    end
    e.data = cpu_rd_m;
    e.err  = mis;
    e.t0   = cyc;
    e.lat  = chk ? lat : 0;
    cpu_q.push_back(e);
    cpu_we    = we;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
  endtask

  task automatic dbg_issue(input logic we, input logic [9:0] addr,
                           input logic [31:0] wd, input bit chk,
                           output int n_ena, output int n_wr);
    exp_t e;
    n_ena = 1;
    n_wr  = we ? 1 : 0;
    if (we) ref_mem[addr] = wd;
    else    dbg_rd_m = ref_mem[addr];
    e.data = dbg_rd_m;
    e.err  = 1'b0;
    e.t0   = cyc;
    e.lat  = chk ? (we ? 2 : 3) : 0;
    dbg_q.push_back(e);
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wd;
    dbg_req   = 1'b1;
  endtask

  task automatic wait_ack(input bit dbg, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dbg ? dbg_ack : cpu_ack) && n < 40);
    if (!(dbg ? dbg_ack : cpu_ack)) begin
      vectors++;
      miscompares++;
      $display("FAIL %s ack timeout after %0d cycles", name, n);
    end
    if (dbg) dbg_req = 1'b0;
    else     cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_ram(input string name, input int e0, input int w0,
                           input int ne, input int nw);
    vectors++;
    if (ena_cnt - e0 != ne || wr_cnt - w0 != nw) begin
      miscompares++;
      $display("FAIL %s ram ena=%0d wr=%0d expected ena=%0d wr=%0d",
               name, ena_cnt - e0, wr_cnt - w0, ne, nw);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [1:0] size,
                        input logic [11:0] addr, input logic [31:0] wd,
                        input string name);
    int e0, w0, ne, nw;
    e0 = ena_cnt;
    w0 = wr_cnt;
    cpu_issue(we, size, addr, wd, 1'b1, ne, nw);
    wait_ack(1'b0, name);
    check_ram(name, e0, w0, ne, nw);
  endtask

  task automatic dbg_op(input logic we, input logic [9:0] addr,
                        input logic [31:0] wd, input string name);
    int e0, w0, ne, nw;
    e0 = ena_cnt;
    w0 = wr_cnt;
    dbg_issue(we, addr, wd, 1'b1, ne, nw);
    wait_ack(1'b1, name);
    check_ram(name, e0, w0, ne, nw);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (cpu_rdata !== '0 || cpu_ack !== 1'b0 || cpu_err !== 1'b0 ||
        dbg_rdata !== '0 || dbg_ack !== 1'b0 || ram_ena !== 1'b0 ||
        ram_wea !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      miscompares++;
      $display("FAIL %s outputs cpu=%h/%b/%b dbg=%h/%b ram=%b/%b/%h/%h expected all 0",
               name, cpu_rdata, cpu_ack, cpu_err, dbg_rdata, dbg_ack,
               ram_ena, ram_wea, ram_addr, ram_wdata);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    cpu_rd_m = '0;
    dbg_rd_m = '0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int          ne, nw, n, dphase;
  bit          cdone, ddone;
  logic [11:0] ra;
  logic [31:0] rd;

  initial begin
    rst = 1'b1; init_mem = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    cpu_rd_m = 0; dbg_rd_m = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    cpu_op(1'b0, 2'b10, 12'h014, 32'h0, "cpu_word_rd");
    dbg_op(1'b1, 10'h010, 32'h11223344, "dbg_word_wr");
    cpu_op(1'b1, 2'b00, 12'h041, 32'h000000AA, "cpu_byte_wr");
    cpu_op(1'b0, 2'b01, 12'h042, 32'h0, "cpu_half_rd");
    cpu_op(1'b0, 2'b00, 12'h041, 32'h0, "cpu_byte_rd");
    cpu_op(1'b1, 2'b01, 12'h043, 32'h0000BEEF, "cpu_half_mis");
    cpu_op(1'b0, 2'b10, 12'h042, 32'h0, "cpu_word_mis");
    dbg_op(1'b0, 10'h010, 32'h0, "dbg_rd_10");
    cpu_op(1'b1, 2'b01, 12'h0A2, 32'h12345678, "cpu_half_wr");
    dbg_op(1'b0, 10'h028, 32'h0, "dbg_rd_28");

    // tie after reset: debug, then CPU, then debug re-request
    do_reset();
    ack_seq.delete();
    dbg_issue(1'b0, 10'd5, 32'h0, 1'b0, ne, nw);
    cpu_issue(1'b0, 2'b10, 12'h018, 32'h0, 1'b0, ne, nw);
    dphase = 0; cdone = 0; ddone = 0; n = 0;
    while (!(cdone && ddone) && n < 60) begin
      @(negedge clk);
      n++;
      if (dbg_ack) begin
        if (dphase == 0) begin
          dphase = 1;
          dbg_issue(1'b0, 10'd7, 32'h0, 1'b0, ne, nw);
        end else begin
          dbg_req = 1'b0;
          ddone = 1;
        end
      end
      if (cpu_ack) begin
        cpu_req = 1'b0;
        cdone = 1;
      end
    end
    @(negedge clk);
    vectors++;
    if (!(cdone && ddone) || ack_seq.size() != 3 || ack_seq[0] != 1 ||
        ack_seq[1] != 0 || ack_seq[2] != 1) begin
      miscompares++;
      $display("FAIL tie_order got %p expected '{1,0,1}", ack_seq);
    end

    // reset during the WR beat of a debug write
    dbg_we = 1'b1; dbg_addr = 10'd3; dbg_wdata = 32'hCAFEF00D;
    dbg_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (!(ram_ena && ram_wea && ram_addr == 10'd3 &&
          ram_wdata == 32'hCAFEF00D)) begin
      miscompares++;
      $display("FAIL wr_beat ena=%b wea=%b addr=%h data=%h expected 1 1 003 cafef00d",
               ram_ena, ram_wea, ram_addr, ram_wdata);
    end
    rst = 1'b1;
    dbg_req = 1'b0;
    @(negedge clk);
    check_zero("rst_in_wr");
    rst = 1'b0;
    ref_mem[3] = 32'hCAFEF00D;
    cpu_rd_m = '0;
    dbg_rd_m = '0;
    repeat (2) @(negedge clk);
    dbg_op(1'b0, 10'd3, 32'h0, "rd_after_rst");

    for (int i = 0; i < 150; i++) begin
      ra = 12'($urandom_range(0, 127));
      rd = $urandom;
      if ($urandom_range(0, 1) == 1)
        cpu_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               ra, rd, "rand_cpu");
      else
        dbg_op(1'($urandom_range(0, 1)), 10'(ra[6:2]), rd, "rand_dbg");
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (cpu_q.size() != 0 || dbg_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover cpu_q=%0d dbg_q=%0d expected 0 0",
               cpu_q.size(), dbg_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_port_ctrl.md
# dmem_port_ctrl

Controller and arbiter for the single-port data-memory BRAM in the MIPS datapath. It shares the one RAM port between the CPU MEM stage and the debug unit using req/ack handshakes. It arbitrates round-robin and sequences every RAM access. Byte and halfword CPU stores become read-modify-write sequences because the RAM has no byte enables.

## Interface
- NB_DATA, 32, data word width
- NB_ADDR, 10, RAM word-address width (depth 2**NB_ADDR)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_cpu_req / i_cpu_we  in  1 / 1  CPU request / write; held stable with all CPU inputs until ack
- i_cpu_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- i_cpu_addr  in  NB_ADDR+2  byte address
- i_cpu_wdata  in  NB_DATA  store data, right-justified
- o_cpu_rdata  out  NB_DATA  load data, lane right-justified, zero-extended
- o_cpu_ack / o_cpu_err  out  1 / 1  one-cycle completion pulse / misalignment flag (valid with ack)
- i_dbg_req / i_dbg_we  in  1 / 1  debug request / write, word-only
- i_dbg_addr  in  NB_ADDR  word address
- i_dbg_wdata  in  NB_DATA  write data
- o_dbg_rdata / o_dbg_ack  out  NB_DATA / 1  read data / one-cycle completion pulse
- o_ram_ena, o_ram_wea  out  1  RAM enable, write enable
- o_ram_addr  out  NB_ADDR  RAM word address
- o_ram_wdata  out  NB_DATA  RAM write data
- i_ram_rdata  in  NB_DATA  RAM output; valid one cycle after an enabled read (LOW_LATENCY RAM)

## Operation
- States: IDLE, RD, CAP, RMW_RD, RMW_MRG, WR, ACK.
- IDLE samples requests. On a grant it latches requester id, address, data, we and size into command registers. RAM outputs are decoded from the state and these registers only.
- Arbitration:
  - One requester: that requester is granted.
  - Both requesting: the one not granted last wins.
  - Last-grant resets to CPU, so debug wins the first tie.
- Word read: IDLE→RD (ena=1, wea=0)→CAP (i_ram_rdata lane-extracted into the rdata register of the requester)→ACK.
- Word write: IDLE→WR (ena=1, wea=1, wdata=latched)→ACK.
- CPU subword write: IDLE→RMW_RD→RMW_MRG (merge store lanes into i_ram_rdata, result into write buffer)→WR (write buffer)→ACK.
- Lanes are little-endian. Byte lane = addr[1:0], lane 0 = bits 7:0. Half lane = addr[1], lower half = bits 15:0.
- Misaligned CPU access (half with addr[0]=1; word with addr[1:0]≠0): IDLE→ACK directly with err=1. The RAM is not enabled and o_cpu_rdata holds its old value.
- ACK pulses the granted requester's ack, then returns to IDLE. A request still held in the following IDLE cycle is a new transaction.
- rdata registers hold their value until the next read by the same requester completes.
- Debug address and size bits are word-only. Debug never misaligns.

## Timing
- Reset values: state IDLE; every output 0; rdata registers 0; last-grant = CPU.
- Ack cycle, counted from the grant edge = c0:
  - misaligned: c1
  - word write: c2
  - read: c3
  - subword write: c4
- Exactly one RAM enable per read or word write. Exactly two per RMW (one read, one write).
- A request arriving while the FSM is busy waits; no request is dropped.
- Reset asserted during WR: the RAM write still commits that edge (ena is already high). No ack is issued and the next state is IDLE.
- Reset in any other state aborts with no RAM write and no ack.

## Configuration
- DMEM_PORT_CTRL_SUBWORD_EN defined: byte/half support, RMW states, and misalignment detection are all present.
- Undefined:
  - i_cpu_size and i_cpu_addr[1:0] are ignored, so every CPU access is a word access.
  - RMW_RD and RMW_MRG do not exist.
  - o_cpu_err is tied to 0.
  - Word latencies are unchanged.

## Structure
- Package dmem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encoding, requester id constants.
- Sub-module dmem_lane_merge: combinational lane extract (load) and lane merge (store), parameterized by NB_DATA.

## Test plan
- RAM preloaded with word[i]=i. CPU word read at byte addr 0x014 → o_cpu_rdata=0x00000005, ack at c3, one RAM enable.
- Debug writes word 0x010 = 0x11223344, then CPU stores byte 0xAA at byte addr 0x041 → word 0x010 = 0x1122AA44, ack at c4, RAM sees one read then one write.
- CPU half load from 0x042 after the previous step → o_cpu_rdata=0x00001122. Byte load from 0x041 → 0x000000AA.
- Both req asserted at the same time after reset → debug acked first, CPU next. Both re-asserted → CPU first.
- CPU half store at 0x043 → ack and err at c1, no ena, word 0x010 unchanged.
- i_rst pulsed in the WR cycle of debug write 0xCAFEF00D to word 0x003 → no ack, outputs 0 next cycle, subsequent read of 0x003 → 0xCAFEF00D.
